// File: rtl/green_pkg.sv
// Shared types and geometry for the green mask sequencer.
// Default mask geometry is 40 x 60; green_count width is defined for GREEN_COUNT_EN builds.
package green_pkg;
  localparam int HEIGHT = 40;
  localparam int LENGTH = 60;
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int COL_W  = $clog2(LENGTH);
  localparam int GC_W   = $clog2(HEIGHT * LENGTH + 1);

  typedef logic [2:0][7:0] rgb_t;

  typedef struct packed {
    rgb_t lower;
    rgb_t upper;
  } thresh_t;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  localparam thresh_t THRESH_RST = '{lower: '0, upper: '1};

  // Inclusive unsigned bounds; an inverted range (lower > upper) can never match.
  function automatic logic is_green(rgb_t pix, thresh_t thr);
    logic ok;
    ok = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      if ((pix[ch] < thr.lower[ch]) || (pix[ch] > thr.upper[ch])) ok = 1'b0;
    end
    return ok;
  endfunction
endpackage

// File: rtl/green_pixel_cmp.sv
// Stage-2 registered compare: turns one stage-1 pixel into a mask buffer write.
// mask bit is 0 for green, 1 otherwise.
module green_pixel_cmp
  import green_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             i_vld_p1,
  input  rgb_t             i_pix_p1,
  input  logic [ROW_W-1:0] i_row_p1,
  input  logic [COL_W-1:0] i_col_p1,
  input  thresh_t          i_thr,
  output logic             o_we_p2,
  output logic [ROW_W-1:0] o_row_p2,
  output logic [COL_W-1:0] o_col_p2,
  output logic             o_bit_p2
);
  logic             r_we_p2;
  logic [ROW_W-1:0] r_row_p2;
  logic [COL_W-1:0] r_col_p2;
  logic             r_bit_p2;

  // stage 2: compare and present the write
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      r_we_p2  <= 1'b0;
      r_row_p2 <= '0;
      r_col_p2 <= '0;
      r_bit_p2 <= 1'b1;
    end else begin
      r_we_p2 <= i_vld_p1;
      if (i_vld_p1) begin
        r_row_p2 <= i_row_p1;
        r_col_p2 <= i_col_p1;
        r_bit_p2 <= ~is_green(i_pix_p1, i_thr);
      end
    end
  end

  assign o_we_p2  = r_we_p2;
  assign o_row_p2 = r_row_p2;
  assign o_col_p2 = r_col_p2;
  assign o_bit_p2 = r_bit_p2;
endmodule

// File: rtl/green_mask_sequencer.sv
// Frames a pixel stream into a HEIGHT x LENGTH green mask with double-buffered thresholds.
// Define GREEN_COUNT_EN to add the per-frame green_count output.
module green_mask_sequencer
  import green_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             run_en,
  input  logic             cfg_wr,
  input  rgb_t             cfg_lower,
  input  rgb_t             cfg_upper,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_sof,
  input  rgb_t             pix_data,
  output logic             mask_we,
  output logic [ROW_W-1:0] mask_row,
  output logic [COL_W-1:0] mask_col,
  output logic             mask_bit,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy
`ifdef GREEN_COUNT_EN
  ,
  output logic [GC_W-1:0]  green_count
`endif
);
  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  thresh_t          r_thr_pend;
  thresh_t          r_thr_act;
  logic             r_frame_done;
  logic             r_frame_err;
  logic             r_vld_p1;
  rgb_t             r_pix_p1;
  logic [ROW_W-1:0] r_row_p1;
  logic [COL_W-1:0] r_col_p1;

  thresh_t          w_cfg;
  logic             w_accept;
  logic             w_restart;
  logic             w_take;
  logic             w_err;
  logic             w_last;
  logic [ROW_W-1:0] w_pix_row;
  logic [COL_W-1:0] w_pix_col;

  assign w_cfg     = '{lower: cfg_lower, upper: cfg_upper};
  assign pix_ready = rst_in_n && ((r_state == STREAM) || ((r_state == IDLE) && run_en));
  assign w_accept  = pix_valid && pix_ready;
  // Any accepted SOF starts a frame at (0,0), including a restart mid-frame.
  assign w_restart = w_accept && pix_sof;
  assign w_take    = w_accept && (pix_sof || (r_state == STREAM));
  assign w_err     = w_accept && (((r_state == IDLE) && !pix_sof) ||
                                  ((r_state == STREAM) && pix_sof));
  assign w_pix_row = w_restart ? '0 : r_row;
  assign w_pix_col = w_restart ? '0 : r_col;
  assign w_last    = (w_pix_row == ROW_W'(HEIGHT - 1)) && (w_pix_col == COL_W'(LENGTH - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_thr_pend   <= THRESH_RST;
      r_thr_act    <= THRESH_RST;
      r_vld_p1     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= w_err;
      r_vld_p1     <= w_take;
      if (cfg_wr) r_thr_pend <= w_cfg;
      if (w_restart) r_thr_act <= cfg_wr ? w_cfg : r_thr_pend;
      if (w_take) begin
        if (w_pix_col == COL_W'(LENGTH - 1)) begin
          r_col <= '0;
          r_row <= w_pix_row + 1'b1;
        end else begin
          r_col <= w_pix_col + 1'b1;
          r_row <= w_pix_row;
        end
      end
      unique case (r_state)
        IDLE:    if (w_take) r_state <= STREAM;
        STREAM:  if (w_take && w_last) r_state <= FLUSH;
        // Last pixel has left stage 1 and its write is on the bus now.
        FLUSH:   if (!r_vld_p1 && mask_we) begin
                   r_state      <= DONE;
                   r_frame_done <= 1'b1;
                 end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // stage 1: capture pixel and its raster position
  always_ff @(posedge clk_in) begin
    if (w_take) begin
      r_pix_p1 <= pix_data;
      r_row_p1 <= w_pix_row;
      r_col_p1 <= w_pix_col;
    end
  end

  green_pixel_cmp u_cmp (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .i_vld_p1 (r_vld_p1),
    .i_pix_p1 (r_pix_p1),
    .i_row_p1 (r_row_p1),
    .i_col_p1 (r_col_p1),
    .i_thr    (r_thr_act),
    .o_we_p2  (mask_we),
    .o_row_p2 (mask_row),
    .o_col_p2 (mask_col),
    .o_bit_p2 (mask_bit)
  );

  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == STREAM) || (r_state == FLUSH);

`ifdef GREEN_COUNT_EN
  // Frame generation tag keeps stragglers of an aborted frame out of the new count.
  logic            r_gen;
  logic            r_gen_p1;
  logic            r_gen_p2;
  logic [GC_W-1:0] r_green_count;

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      r_gen         <= 1'b0;
      r_green_count <= '0;
    end else if (w_restart) begin
      r_gen         <= ~r_gen;
      r_green_count <= '0;
    end else if (mask_we && !mask_bit && (r_gen_p2 == r_gen)) begin
      r_green_count <= r_green_count + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_take) r_gen_p1 <= w_restart ? ~r_gen : r_gen;
    r_gen_p2 <= r_gen_p1;
  end

  assign green_count = r_green_count;
`endif
endmodule
